// File: rtl/adc_capture_pkg.sv
// -----------------------------------------------------------------------------
// adc_capture_pkg
// Shared constants and types for the ADC sample-capture front end.
//   ADC_DATA_W      : native ADC sample width
//   DEF_CLK_DIV     : default adc_clock half-period, in system clock cycles
//   DEF_FIFO_DEPTH  : default number of buffered samples (power of two, >= 2)
//   adc_sample_t    : one raw ADC sample
// -----------------------------------------------------------------------------
package adc_capture_pkg;

  localparam int ADC_DATA_W     = 8;
  localparam int DEF_CLK_DIV    = 4;
  localparam int DEF_FIFO_DEPTH = 8;

  typedef logic [ADC_DATA_W-1:0] adc_sample_t;

endpackage : adc_capture_pkg

// File: rtl/adc_sample_fifo.sv
// -----------------------------------------------------------------------------
// adc_sample_fifo
// First-word-fall-through sample FIFO with drop-on-full.
// A push while full is accepted only if a pop happens on the same edge;
// otherwise the incoming sample is discarded and the contents are unchanged.
//
// Ports:
//   clock      in   system clock
//   reset_n    in   asynchronous active-low reset (pointers and level only)
//   push       in   write push_data this edge (subject to the full rule)
//   push_data  in   sample to write
//   pop        in   remove the head entry this edge (ignored when empty)
//   head       out  head entry, reads 0 when empty
//   full       out  level == DEPTH
//   empty      out  level == 0
//   level      out  current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module adc_sample_fifo
  import adc_capture_pkg::*;
#(
  parameter int DEPTH  = DEF_FIFO_DEPTH,
  parameter int DATA_W = ADC_DATA_W
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == LW'(DEPTH));
    do_pop   = pop & ~empty;
    // A full FIFO still takes a sample when the head leaves on the same edge.
    do_push  = push & (~full | do_pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    // Pointers are exactly log2(DEPTH) wide, so they wrap without compare.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of evaluation order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; level and pointers
  // define which entries are meaningful, and head is masked while empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign head  = empty ? '0 : mem[rd_ptr_q];
  assign level = level_q;

endmodule : adc_sample_fifo

// File: rtl/adc_sample_capture.sv
// -----------------------------------------------------------------------------
// adc_sample_capture
// Digital front end of the on-chip ADC: generates adc_clock, captures adc_data
// on each falling adc_clock edge and buffers samples in a FWFT FIFO that is
// drained over a valid/ready stream.
//
// Optional feature: define ADC_CAPTURE_AVG_EN to average each pair of
// consecutive captures into one pushed sample ((a+b)>>1).
//
// Ports:
//   clock           in   system clock (only clock in the block)
//   reset_n         in   asynchronous active-low reset
//   enable          in   runs divider and capture; low parks adc_clock at 0
//   adc_clock       out  registered ADC clock, clock/(2*CLK_DIV), 50 % duty
//   adc_data        in   ADC conversion result
//   out_valid       out  FIFO non-empty
//   out_ready       in   consumer accepts out_bits this edge
//   out_bits        out  head-of-FIFO sample, 0 when empty
//   overflow        out  sticky: a sample was dropped on a full FIFO
//   overflow_clear  in   clears overflow (a same-cycle drop wins)
//   level           out  FIFO occupancy
// -----------------------------------------------------------------------------
module adc_sample_capture
  import adc_capture_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int DATA_W     = ADC_DATA_W
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          enable,
  output logic                          adc_clock,
  input  logic [DATA_W-1:0]             adc_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_bits,
  output logic                          overflow,
  input  logic                          overflow_clear,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  // CLK_DIV is at most 255, so an 8-bit counter always suffices.
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0]        div_cnt_q, div_cnt_d;
  logic              adc_clock_q, adc_clock_d;
  logic              overflow_q, overflow_d;
  logic              div_terminal;
  logic              cap;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;

  // ---------------------------------------------------------------------------
  // Divider and capture strobe
  // ---------------------------------------------------------------------------
  always_comb begin
    div_terminal = (div_cnt_q == DIV_LAST);
    div_cnt_d    = div_cnt_q;
    adc_clock_d  = adc_clock_q;

    if (!enable) begin
      div_cnt_d   = '0;
      adc_clock_d = 1'b0;
    end else if (div_terminal) begin
      div_cnt_d   = '0;
      adc_clock_d = ~adc_clock_q;
    end else begin
      div_cnt_d   = div_cnt_q + 1'b1;
    end

    // Sample on the edge where adc_clock falls: the ADC updated on the rising
    // edge, so the data has had half an ADC period to settle.
    cap = enable & div_terminal & adc_clock_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q   <= '0;
      adc_clock_q <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      adc_clock_q <= adc_clock_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Push path: raw captures, or averaged pairs when the feature is built in
  // ---------------------------------------------------------------------------
`ifdef ADC_CAPTURE_AVG_EN
  logic              phase_q, phase_d;   // 0: next capture is a, 1: next is b
  logic [DATA_W-1:0] hold_q, hold_d;     // first half of the pair
  logic [DATA_W:0]   pair_sum;

  always_comb begin
    phase_d   = phase_q;
    hold_d    = hold_q;
    push      = 1'b0;
    pair_sum  = {1'b0, hold_q} + {1'b0, adc_data};
    push_data = pair_sum[DATA_W:1];

    if (!enable) begin
      // Dropping enable abandons any half-collected pair.
      phase_d = 1'b0;
    end else if (cap) begin
      if (!phase_q) begin
        hold_d  = adc_data;
        phase_d = 1'b1;
      end else begin
        push    = 1'b1;
        phase_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      phase_q <= phase_d;
      hold_q  <= hold_d;
    end
  end
`else
  always_comb begin
    push      = cap;
    push_data = adc_data;
  end
`endif

  // ---------------------------------------------------------------------------
  // Sample FIFO and stream interface
  // ---------------------------------------------------------------------------
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  adc_sample_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (out_bits),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  // ---------------------------------------------------------------------------
  // Sticky overflow: a dropped sample sets it, and setting beats clearing.
  // ---------------------------------------------------------------------------
  always_comb begin
    overflow_d = (push & fifo_full & ~pop) | (overflow_q & ~overflow_clear);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) overflow_q <= 1'b0;
    else          overflow_q <= overflow_d;
  end

  assign adc_clock = adc_clock_q;
  assign overflow  = overflow_q;

endmodule : adc_sample_capture

// File: tb/tb_adc_sample_capture.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_capture
// Self-checking bench for adc_sample_capture (CLK_DIV=2, FIFO_DEPTH=8).
// A reference model derives adc_clock and capture edges arithmetically from
// the number of enabled edges, and keeps the FIFO as a queue. Every cycle the
// DUT outputs are compared with the model; phase tables and hand sequences add
// checks against fixed expected values.
// -----------------------------------------------------------------------------
module tb_adc_sample_capture;
  import adc_capture_pkg::*;

  localparam int CD    = 2;
  localparam int DEPTH = 8;

`ifdef ADC_CAPTURE_AVG_EN
  localparam int FIRST_VALID  = 4 * CD;
  localparam int EXP_SEQ0     = 'h10;
  localparam int EXP_SEQ1     = 'h12;
  localparam int EXP_SEQ2     = 'h14;
  localparam int DROP_LEVEL   = 1;
`else
  localparam int FIRST_VALID  = 2 * CD;
  localparam int EXP_SEQ0     = 'h10;
  localparam int EXP_SEQ1     = 'h11;
  localparam int EXP_SEQ2     = 'h12;
  localparam int DROP_LEVEL   = 3;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        adc_clock;
  adc_sample_t adc_data;
  logic        out_valid;
  logic        out_ready;
  adc_sample_t out_bits;
  logic        overflow;
  logic        overflow_clear;
  logic [3:0]  level;

  int total = 0;
  int bad   = 0;

  adc_sample_capture #(
    .CLK_DIV    (CD),
    .FIFO_DEPTH (DEPTH),
    .DATA_W     (ADC_DATA_W)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .adc_clock      (adc_clock),
    .adc_data       (adc_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_bits       (out_bits),
    .overflow       (overflow),
    .overflow_clear (overflow_clear),
    .level          (level)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  int  m_k;          // enabled edges since enable last low
  bit  m_clk, m_prev_clk;
  int  m_q[$];       // FIFO contents, head at index 0
  bit  m_ovf;
  bit  m_phase;
  int  m_hold;
  int  data_q[$];    // scripted adc_data values, applied one per adc_clock rise
  int  seen[$];      // values actually popped from the DUT

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_clk = 0; m_prev_clk = 0;
    m_q.delete(); m_ovf = 0; m_phase = 0; m_hold = 0;
  endtask

  task automatic model_edge();
    bit do_pop, do_push, drop;
    int pv;
    do_pop  = out_ready && (m_q.size() > 0);
    do_push = 0;
    pv      = 0;
    m_prev_clk = m_clk;
    if (!enable) begin
      m_k = 0; m_clk = 0; m_phase = 0;
    end else begin
      m_k++;
      m_clk = ((m_k / CD) % 2) == 1;
      if ((m_k % (2 * CD)) == 0) begin
`ifdef ADC_CAPTURE_AVG_EN
        if (!m_phase) begin
          m_hold = int'(adc_data); m_phase = 1;
        end else begin
          do_push = 1; pv = (m_hold + int'(adc_data)) / 2; m_phase = 0;
        end
`else
        do_push = 1; pv = int'(adc_data);
`endif
      end
    end
    drop = do_push && (m_q.size() == DEPTH) && !do_pop;
    if (do_pop) void'(m_q.pop_front());
    if (do_push && !drop) m_q.push_back(pv);
    m_ovf = drop || (m_ovf && !overflow_clear);
  endtask

  task automatic compare();
    check("adc_clock", adc_clock, m_clk);
    check("out_valid", out_valid, m_q.size() > 0);
    check("out_bits",  out_bits,  (m_q.size() > 0) ? m_q[0] : 0);
    check("level",     level,     m_q.size());
    check("overflow",  overflow,  m_ovf);
  endtask

  // One clock: inputs are already set; model the edge, then compare at negedge.
  task automatic cycle();
    if (out_valid && out_ready) seen.push_back(int'(out_bits));
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare();
    if (m_clk && !m_prev_clk)
      adc_data = (data_q.size() > 0) ? 8'(data_q.pop_front()) : 8'($urandom);
  endtask

  task automatic run(input bit en, input bit rdy, input bit clr, input int n);
    enable = en; out_ready = rdy; overflow_clear = clr;
    for (int i = 0; i < n; i++) cycle();
    overflow_clear = 0;
  endtask

  typedef struct {
    bit en; bit rdy; bit clr; int cycles; int exp_level; bit exp_ovf;
  } phase_t;

  phase_t tbl [7];

  initial begin
    int rises[$];
    int first_valid;
    bit prev;
    int tail;

    // Phase table: enable/ready/clear held for a number of cycles, then the
    // occupancy and overflow flag are compared with the listed values.
`ifdef ADC_CAPTURE_AVG_EN
    tbl[0] = '{0, 1, 1,  4, 0, 0};
    tbl[1] = '{1, 0, 0, 35, 4, 0};
    tbl[2] = '{1, 0, 0,  4, 4, 0};
    tbl[3] = '{1, 0, 0,  4, 5, 0};
    tbl[4] = '{0, 0, 1,  1, 5, 0};
    tbl[5] = '{0, 1, 0,  8, 0, 0};
    tbl[6] = '{1, 0, 0, 35, 4, 0};
`else
    tbl[0] = '{0, 1, 1,  4, 0, 0};   // drain and park
    tbl[1] = '{1, 0, 0, 35, 8, 0};   // 8 captures fill the FIFO
    tbl[2] = '{1, 0, 0,  4, 8, 1};   // 9th capture dropped
    tbl[3] = '{1, 0, 0,  4, 8, 1};   // 10th capture dropped
    tbl[4] = '{0, 0, 1,  1, 8, 0};   // clear the flag
    tbl[5] = '{0, 1, 0,  8, 0, 0};   // first 8 samples drain in order
    tbl[6] = '{1, 0, 0, 35, 8, 0};   // refill, next edge is a capture
`endif

    // ---------------- Reset state ----------------
    reset_n = 0; enable = 0; out_ready = 0; overflow_clear = 0; adc_data = '0;
    model_reset();
    #2;
    check("rst_adc_clock", adc_clock, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bits",  out_bits,  0);
    check("rst_level",     level,     0);
    check("rst_overflow",  overflow,  0);
    @(negedge clock);
    reset_n = 1;
    run(0, 0, 0, 2);

    // ---------------- Divider and capture ----------------
    for (int i = 0; i < 16; i++) data_q.push_back('h10 + i);
    seen.delete();
    enable = 1; out_ready = 1;
    first_valid = -1; prev = adc_clock;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (adc_clock && !prev) rises.push_back(i);
      prev = adc_clock;
      if (out_valid && first_valid < 0) first_valid = i;
      check("level_le_1", level <= 1, 1);
    end
    check("rise_count_ge2", rises.size() >= 2, 1);
    if (rises.size() >= 2) begin
      check("first_rise", rises[0], CD);
      check("adc_clock_period", rises[1] - rises[0], 2 * CD);
    end
    check("first_valid", first_valid, FIRST_VALID);
    check("seen_count_ge3", seen.size() >= 3, 1);
    if (seen.size() >= 3) begin
      check("seq0", seen[0], EXP_SEQ0);
      check("seq1", seen[1], EXP_SEQ1);
      check("seq2", seen[2], EXP_SEQ2);
    end
    data_q.delete();

    // ---------------- Overflow table ----------------
    for (int p = 0; p < 7; p++) begin
      run(tbl[p].en, tbl[p].rdy, tbl[p].clr, tbl[p].cycles);
      check($sformatf("tbl%0d_level", p), level, tbl[p].exp_level);
      check($sformatf("tbl%0d_overflow", p), overflow, tbl[p].exp_ovf);
    end

    // ---------------- Full with simultaneous pop ----------------
    tail = int'(adc_data);
    run(1, 1, 0, 1);
    seen.delete();
`ifndef ADC_CAPTURE_AVG_EN
    check("fullpop_level", level, 8);
    check("fullpop_overflow", overflow, 0);
`endif
    run(0, 1, 0, 8);
`ifndef ADC_CAPTURE_AVG_EN
    check("fullpop_drained", seen.size(), 8);
    if (seen.size() == 8) check("fullpop_tail", seen[7], tail);
`endif
    run(0, 1, 0, 4);

    // ---------------- Enable drop ----------------
    run(1, 0, 0, 14);
    run(0, 0, 0, 1);
    check("disable_adc_clock", adc_clock, 0);
    run(0, 0, 0, 10);
    check("disable_no_push", level, DROP_LEVEL);
    run(0, 1, 0, 10);
    check("disable_drained", level, 0);

`ifdef ADC_CAPTURE_AVG_EN
    // ---------------- Averaging pairs ----------------
    run(0, 0, 1, 1);
    data_q = '{'hFF, 'hFE, 'h01, 'h02};
    seen.delete();
    run(1, 1, 0, 17);
    check("avg_push_count", seen.size(), 2);
    if (seen.size() == 2) begin
      check("avg_ff_fe", seen[0], 'hFE);
      check("avg_01_02", seen[1], 'h01);
    end
    data_q.delete();
`endif

    // ---------------- Randomized traffic ----------------
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 100; i++) begin
        enable         = ($urandom % 16) != 0;
        out_ready      = ($urandom % 8) < (b * 2);
        overflow_clear = ($urandom % 16) == 0;
        cycle();
      end
    end
    overflow_clear = 0;

    // ---------------- Reset mid-operation ----------------
    run(0, 1, 1, 10);
    run(1, 0, 0, 39);
    run(0, 1, 0, 3);
`ifndef ADC_CAPTURE_AVG_EN
    check("prereset_level", level, 5);
    check("prereset_overflow", overflow, 1);
`endif
    out_ready = 0;
    #2 reset_n = 0;
    #1;
    check("midrst_adc_clock", adc_clock, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_bits",  out_bits,  0);
    check("midrst_level",     level,     0);
    check("midrst_overflow",  overflow,  0);
    model_reset();
    @(negedge clock);
    reset_n = 1;
    run(0, 1, 0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_adc_sample_capture
